alu_cmd_issuer: RTL and testbench
=================================

# alu_cmd_issuer

Command-side front end for the 4-bit combinational ALU: accepts tagged operation requests over a valid/ready handshake, drives the ALU operand and select inputs from registers, captures the 8-bit result, and returns it through a small response FIFO with its own valid/ready handshake. It sits between a command source (sequencer or bus slave) and the ALU, so that the ALU's inputs are always register-driven and its results can be back-pressured.

## Interface
Parameters:
- `TAG_W`, default 2: width of the request tag, returned unchanged with the response.
- `RSP_DEPTH`, default 2: number of response FIFO entries; a power of two, at least 2.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `cmd_valid`, input, 1: request present.
- `cmd_ready`, output, 1: issuer can accept a request.
- `cmd_a`, input, 4: operand A.
- `cmd_b`, input, 4: operand B.
- `cmd_sel`, input, 4: ALU opcode, passed through to the ALU unchanged.
- `cmd_tag`, input, TAG_W: request tag.
- `alu_a`, output, 4: registered operand A driven to the ALU.
- `alu_b`, output, 4: registered operand B driven to the ALU.
- `alu_sel`, output, 4: registered opcode driven to the ALU.
- `alu_out`, input, 8: combinational ALU result.
- `rsp_valid`, output, 1: response FIFO not empty.
- `rsp_ready`, input, 1: consumer accepts the head response.
- `rsp_data`, output, 8: head result.
- `rsp_tag`, output, TAG_W: head tag.
- `rsp_err`, output, 1: head error flag (see Configuration).

## Operation
- State machine with two states:
  - **IDLE:** `cmd_ready` = (FIFO count < RSP_DEPTH), combinational. On `cmd_valid && cmd_ready`, the block loads `alu_a`/`alu_b`/`alu_sel` from `cmd_a`/`cmd_b`/`cmd_sel`, latches `cmd_tag`, and moves to ISSUE.
  - **ISSUE:** `cmd_ready` = 0. `alu_*` are held stable so the ALU settles. At the end of the cycle the block pushes {`alu_out`, tag, err} into the FIFO and returns to IDLE.
- `alu_a`/`alu_b`/`alu_sel` change only on command acceptance. Between commands they hold the last issued values.
- Response FIFO:
  - `rsp_valid` = (count != 0). The `rsp_data`/`rsp_tag`/`rsp_err` fields are the head entry, held stable while `rsp_valid && !rsp_ready`.
  - A pop occurs on `rsp_valid && rsp_ready`.
  - A push and a pop in the same cycle leave the count unchanged; the pushed entry goes behind the remaining entries.
  - Read and write pointers wrap modulo RSP_DEPTH.
  - Push never happens when full. This is guaranteed because `cmd_ready` excludes the full case and ISSUE lasts exactly one cycle.
- A pop in the same cycle that `cmd_ready` is evaluated does not raise `cmd_ready`. `cmd_ready` is based on the registered count.
- Result width: `alu_out` is captured as the full 8 bits, with no truncation or sign handling in this block.
- Reset mid-operation: an in-flight ISSUE is discarded, the FIFO is emptied, and the state returns to IDLE. No response is produced for discarded requests.

## Timing
- Reset values:
  - `alu_a`/`alu_b`/`alu_sel` = 0; `rsp_data` = 0; `rsp_tag` = 0; `rsp_err` = 0; `rsp_valid` = 0; state IDLE.
  - `cmd_ready` = 1 in the first cycle after reset deasserts.
- Latency: a command accepted in cycle N drives `alu_*` in cycle N+1. When the FIFO was empty, `rsp_valid` = 1 in cycle N+2.
- Throughput: at most one command per 2 cycles (IDLE/ISSUE alternate).
- Back-pressure: with `rsp_ready` held low, exactly RSP_DEPTH commands are accepted, then `cmd_ready` stays 0 until the cycle after the first pop.
- No combinational path from `cmd_*` to `rsp_*`. No combinational path from `rsp_ready` to `cmd_ready`.

## Configuration
- Macro `ALU_ISSUE_DIVZERO_CHK_EN`, defined:
  - When the captured command has `alu_sel` = 4'b0011 (division) and `alu_b` = 0, the pushed entry has `rsp_err` = 1 and `rsp_data` = 8'hFF, and `alu_out` is ignored.
  - All other operations push `rsp_err` = 0.
- Undefined:
  - `rsp_err` is constant 0 and `alu_out` is always captured.
  - A divide by zero returns whatever the ALU produces (X in simulation).

## Test plan
- Add: a=7, b=9, sel=0000, tag=1, accepted in cycle N -> `rsp_valid` in N+2 with `rsp_data`=8'h10, `rsp_tag`=1, `rsp_err`=0.
- Subtract and multiply back-to-back: (3,5,0001) then (15,15,0010) -> responses in order 8'hFE then 8'hE1; `cmd_ready` low during each ISSUE cycle.
- Divide by zero with macro defined: a=9, b=0, sel=0011 -> `rsp_data`=8'hFF, `rsp_err`=1. Without the macro -> `rsp_err`=0.
- Back-pressure: `rsp_ready`=0, offer 3 commands -> 2 accepted, third stalls with `cmd_ready`=0. Raise `rsp_ready` for one cycle -> third accepted the following cycle, and order and tags are preserved.
- Simultaneous push/pop: FIFO holding 1 entry, `rsp_ready`=1 during an ISSUE cycle -> count stays 1, and the next head is the new result.
- Reset during ISSUE with 1 FIFO entry -> next cycle `rsp_valid`=0, `alu_*`=0, `cmd_ready`=1, and no stale response appears afterward.

Source files
------------

// File: rtl/alu_cmd_issuer.sv
// -----------------------------------------------------------------------------
// alu_cmd_issuer
//
// Command-side front end for a 4-bit combinational ALU. Requests arrive over
// a valid/ready handshake, are registered onto the ALU operand/select inputs,
// and one cycle later the 8-bit ALU result is captured into a small response
// FIFO. The FIFO is drained through its own valid/ready handshake, so results
// can be back-pressured while the ALU inputs stay register-driven.
//
// Parameters:
//   TAG_W      width of the request tag, echoed back with the response
//   RSP_DEPTH  response FIFO entries (power of two, >= 2)
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   cmd_valid / cmd_ready    request handshake
//   cmd_a, cmd_b, cmd_sel    operands and opcode of the request
//   cmd_tag                  request tag
//   alu_a, alu_b, alu_sel    registered ALU inputs
//   alu_out                  combinational ALU result
//   rsp_valid / rsp_ready    response handshake
//   rsp_data, rsp_tag        head result and tag
//   rsp_err                  head error flag
//
// Build option:
//   ALU_ISSUE_DIVZERO_CHK_EN  when defined, a division (sel 4'b0011) with a
//                             zero divisor returns 8'hFF with rsp_err set
//                             instead of the ALU result. When undefined,
//                             rsp_err is always 0 and alu_out is always taken.
// -----------------------------------------------------------------------------
module alu_cmd_issuer #(
  parameter int TAG_W     = 2,
  parameter int RSP_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  input  logic [3:0]       cmd_sel,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [3:0]       alu_sel,
  input  logic [7:0]       alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err
);

  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RSP_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

  // FSM and ALU-side registers
  state_e           state_q, state_d;
  logic [3:0]       alu_a_q, alu_a_d;
  logic [3:0]       alu_b_q, alu_b_d;
  logic [3:0]       alu_sel_q, alu_sel_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  // Response FIFO storage and bookkeeping
  logic [7:0]       fifo_data_q [RSP_DEPTH];
  logic [TAG_W-1:0] fifo_tag_q  [RSP_DEPTH];
  logic             fifo_err_q  [RSP_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Combinational control
  logic             cmd_ready_s;
  logic             push_s;
  logic             pop_s;
  logic [7:0]       push_data_s;
  logic             push_err_s;

  // Next-state and handshake logic of the IDLE/ISSUE sequencer
  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    tag_d       = tag_q;
    cmd_ready_s = 1'b0;
    push_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Based on the registered count only: a pop this cycle does not
        // open the door until next cycle, which keeps rsp_ready off the
        // cmd_ready path.
        cmd_ready_s = (count_q < DEPTH_C);
        if (cmd_valid && cmd_ready_s) begin
          alu_a_d   = cmd_a;
          alu_b_d   = cmd_b;
          alu_sel_d = cmd_sel;
          tag_d     = cmd_tag;
          state_d   = ST_ISSUE;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // ALU inputs have been stable for the whole cycle; take the result.
        // The full case was excluded at acceptance, so this push always fits.
        push_s  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Result and error flag written into the FIFO on a push
`ifdef ALU_ISSUE_DIVZERO_CHK_EN
  always_comb begin
    if ((alu_sel_q == 4'b0011) && (alu_b_q == 4'd0)) begin
      push_data_s = 8'hFF;
      push_err_s  = 1'b1;
    end else begin
      push_data_s = alu_out;
      push_err_s  = 1'b0;
    end
  end
`else
  always_comb begin
    push_data_s = alu_out;
    push_err_s  = 1'b0;
  end
`endif

  // FIFO pointer and occupancy update
  always_comb begin
    pop_s    = (count_q != {CNT_W{1'b0}}) && rsp_ready;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Control and ALU-side state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      alu_a_q   <= 4'd0;
      alu_b_q   <= 4'd0;
      alu_sel_q <= 4'd0;
      tag_q     <= {TAG_W{1'b0}};
      rd_ptr_q  <= {PTR_W{1'b0}};
      wr_ptr_q  <= {PTR_W{1'b0}};
      count_q   <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_sel_q <= alu_sel_d;
      tag_q     <= tag_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
    end
  end

  // FIFO entry storage; cleared on reset so the idle head reads as zero
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RSP_DEPTH; i++) begin
        fifo_data_q[i] <= 8'h00;
        fifo_tag_q[i]  <= {TAG_W{1'b0}};
        fifo_err_q[i]  <= 1'b0;
      end
    end else if (push_s) begin
      fifo_data_q[wr_ptr_q] <= push_data_s;
      fifo_tag_q[wr_ptr_q]  <= tag_q;
      fifo_err_q[wr_ptr_q]  <= push_err_s;
    end else begin
      fifo_data_q[wr_ptr_q] <= fifo_data_q[wr_ptr_q];
      fifo_tag_q[wr_ptr_q]  <= fifo_tag_q[wr_ptr_q];
      fifo_err_q[wr_ptr_q]  <= fifo_err_q[wr_ptr_q];
    end
  end

  // All outputs come straight from registers (or a register-indexed mux)
  assign cmd_ready = cmd_ready_s;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_valid = (count_q != {CNT_W{1'b0}});
  assign rsp_data  = fifo_data_q[rd_ptr_q];
  assign rsp_tag   = fifo_tag_q[rd_ptr_q];
  assign rsp_err   = fifo_err_q[rd_ptr_q];

endmodule

// File: tb/tb_alu_cmd_issuer.sv
module tb_alu_cmd_issuer;

  localparam int TAG_W     = 2;
  localparam int RSP_DEPTH = 2;

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_a;
  logic [3:0]       cmd_b;
  logic [3:0]       cmd_sel;
  logic [TAG_W-1:0] cmd_tag;
  logic [3:0]       alu_a;
  logic [3:0]       alu_b;
  logic [3:0]       alu_sel;
  logic [7:0]       alu_out;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [7:0]       rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;

  alu_cmd_issuer #(.TAG_W(TAG_W), .RSP_DEPTH(RSP_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the combinational ALU
  function automatic logic [7:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] sel);
    logic [7:0] ea, eb;
    ea = {4'd0, a};
    eb = {4'd0, b};
    case (sel)
      4'd0:    return ea + eb;
      4'd1:    return ea - eb;
      4'd2:    return ea * eb;
      4'd3:    return (b == 4'd0) ? 8'h00 : (ea / eb);
      4'd4:    return ea & eb;
      4'd5:    return ea | eb;
      4'd6:    return ea ^ eb;
      4'd7:    return {4'd0, ~a};
      default: return {a, b};
    endcase
  endfunction

  assign alu_out = alu_fn(alu_a, alu_b, alu_sel);

  typedef struct packed {
    logic [7:0]       d;
    logic [TAG_W-1:0] t;
    logic             e;
  } rsp_t;

  typedef struct {
    logic [3:0]       a;
    logic [3:0]       b;
    logic [3:0]       sel;
    logic [TAG_W-1:0] tag;
    logic [7:0]       d;
    logic             e;
  } vec_t;

  int n_run  = 0;
  int n_fail = 0;

  // Reference model state: a queue of responses owed, plus one issue in flight
  rsp_t       mq[$];
  bit         pend_v;
  rsp_t       pend_r;
  logic [3:0] ea, eb, es;

  function automatic rsp_t ref_rsp(input logic [3:0] a, input logic [3:0] b,
                                   input logic [3:0] sel, input logic [TAG_W-1:0] tag);
    rsp_t r;
    r.t = tag;
    r.e = 1'b0;
    r.d = alu_fn(a, b, sel);
`ifdef ALU_ISSUE_DIVZERO_CHK_EN
    if ((sel == 4'd3) && (b == 4'd0)) begin
      r.d = 8'hFF;
      r.e = 1'b1;
    end
`endif
    return r;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: predict, step the model, compare after the edge
  task automatic cycle(output bit acc);
    bit exp_rdy, pop, do_rst;
    logic [3:0] ca, cb, cs;
    logic [TAG_W-1:0] ct;
    exp_rdy = !pend_v && (mq.size() < RSP_DEPTH);
    chk("cmd_ready", 8'(cmd_ready), 8'(exp_rdy));
    acc    = cmd_valid && exp_rdy;
    pop    = (mq.size() != 0) && rsp_ready;
    do_rst = rst;
    ca = cmd_a; cb = cmd_b; cs = cmd_sel; ct = cmd_tag;
    @(posedge clk);
    #1;
    if (do_rst) begin
      mq.delete();
      pend_v = 1'b0;
      ea = 4'd0; eb = 4'd0; es = 4'd0;
      acc = 1'b0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (pend_v) mq.push_back(pend_r);
      pend_v = acc;
      if (acc) begin
        pend_r = ref_rsp(ca, cb, cs, ct);
        ea = ca; eb = cb; es = cs;
      end
    end
    chk("alu_a", 8'(alu_a), 8'(ea));
    chk("alu_b", 8'(alu_b), 8'(eb));
    chk("alu_sel", 8'(alu_sel), 8'(es));
    chk("rsp_valid", 8'(rsp_valid), 8'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("rsp_data", rsp_data, mq[0].d);
      chk("rsp_tag", 8'(rsp_tag), 8'(mq[0].t));
      chk("rsp_err", 8'(rsp_err), 8'(mq[0].e));
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] sel, input logic [TAG_W-1:0] tag);
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_tag = tag;
  endtask

  task automatic drain();
    bit acc;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 16 && (mq.size() != 0 || pend_v); i++) cycle(acc);
    chk("drain_empty", 8'(rsp_valid), 8'd0);
    rsp_ready = 1'b0;
  endtask

  vec_t tv [11];
  vec_t bp [3];

  initial begin
    bit acc;
    int n_acc;

    tv[0]  = '{4'd7,  4'd9,  4'd0, 2'd1, 8'h10, 1'b0};
    tv[1]  = '{4'd3,  4'd5,  4'd1, 2'd2, 8'hFE, 1'b0};
    tv[2]  = '{4'd15, 4'd15, 4'd2, 2'd3, 8'hE1, 1'b0};
    tv[3]  = '{4'd9,  4'd3,  4'd3, 2'd0, 8'h03, 1'b0};
    tv[4]  = '{4'd12, 4'd10, 4'd4, 2'd1, 8'h08, 1'b0};
    tv[5]  = '{4'd12, 4'd10, 4'd5, 2'd2, 8'h0E, 1'b0};
    tv[6]  = '{4'd12, 4'd10, 4'd6, 2'd3, 8'h06, 1'b0};
    tv[7]  = '{4'd5,  4'd0,  4'd7, 2'd0, 8'h0A, 1'b0};
    tv[8]  = '{4'd0,  4'd15, 4'd1, 2'd1, 8'hF1, 1'b0};
    tv[9]  = '{4'd15, 4'd1,  4'd0, 2'd2, 8'h10, 1'b0};
`ifdef ALU_ISSUE_DIVZERO_CHK_EN
    tv[10] = '{4'd9,  4'd0,  4'd3, 2'd3, 8'hFF, 1'b1};
`else
    tv[10] = '{4'd9,  4'd0,  4'd3, 2'd3, 8'h00, 1'b0};
`endif

    bp[0] = '{4'd1, 4'd2, 4'd0, 2'd1, 8'h03, 1'b0};
    bp[1] = '{4'd4, 4'd4, 4'd2, 2'd2, 8'h10, 1'b0};
    bp[2] = '{4'd8, 4'd3, 4'd1, 2'd3, 8'h05, 1'b0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_a = 4'd0; cmd_b = 4'd0; cmd_sel = 4'd0;
    cmd_tag = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    pend_v = 1'b0; ea = 4'd0; eb = 4'd0; es = 4'd0;

    // Reset values in the first cycle after reset
    chk("rst_cmd_ready", 8'(cmd_ready), 8'd1);
    chk("rst_rsp_valid", 8'(rsp_valid), 8'd0);
    chk("rst_alu_a", 8'(alu_a), 8'd0);
    chk("rst_alu_b", 8'(alu_b), 8'd0);
    chk("rst_alu_sel", 8'(alu_sel), 8'd0);
    chk("rst_rsp_data", rsp_data, 8'd0);
    chk("rst_rsp_tag", 8'(rsp_tag), 8'd0);
    chk("rst_rsp_err", 8'(rsp_err), 8'd0);

    // Table: one command at a time, response checked two cycles after accept
    for (int i = 0; i < 11; i++) begin
      drive(tv[i].a, tv[i].b, tv[i].sel, tv[i].tag);
      acc = 1'b0;
      for (int k = 0; k < 4 && !acc; k++) cycle(acc);
      chk("tbl_accept", 8'(acc), 8'd1);
      cmd_valid = 1'b0;
      chk("tbl_valid_n1", 8'(rsp_valid), 8'd0);
      cycle(acc);
      chk("tbl_valid_n2", 8'(rsp_valid), 8'd1);
      chk("tbl_data", rsp_data, tv[i].d);
      chk("tbl_tag", 8'(rsp_tag), 8'(tv[i].tag));
      chk("tbl_err", 8'(rsp_err), 8'(tv[i].e));
      rsp_ready = 1'b1;
      cycle(acc);
      rsp_ready = 1'b0;
    end

    // Back-to-back subtract then multiply; second waits out the ISSUE cycle
    rsp_ready = 1'b1;
    drive(4'd3, 4'd5, 4'd1, 2'd1);
    cycle(acc);
    drive(4'd15, 4'd15, 4'd2, 2'd2);
    chk("b2b_issue_ready", 8'(cmd_ready), 8'd0);
    cycle(acc);
    chk("b2b_ready_again", 8'(cmd_ready), 8'd1);
    chk("b2b_first_data", rsp_data, 8'hFE);
    cycle(acc);
    cmd_valid = 1'b0;
    chk("b2b_issue2_ready", 8'(cmd_ready), 8'd0);
    cycle(acc);
    chk("b2b_second_data", rsp_data, 8'hE1);
    drain();

    // Back-pressure: two accepted, third stalls until one pop
    rsp_ready = 1'b0;
    n_acc = 0;
    for (int c = 0; c < 8 && n_acc < 2; c++) begin
      drive(bp[n_acc].a, bp[n_acc].b, bp[n_acc].sel, bp[n_acc].tag);
      cycle(acc);
      if (acc) n_acc++;
    end
    chk("bp_two_accepted", 8'(n_acc), 8'd2);
    drive(bp[2].a, bp[2].b, bp[2].sel, bp[2].tag);
    for (int c = 0; c < 4; c++) begin
      cycle(acc);
      chk("bp_stall", 8'(cmd_ready), 8'd0);
    end
    rsp_ready = 1'b1;
    chk("bp_pop_cycle_ready", 8'(cmd_ready), 8'd0);
    cycle(acc);
    rsp_ready = 1'b0;
    chk("bp_ready_after_pop", 8'(cmd_ready), 8'd1);
    chk("bp_head_tag", 8'(rsp_tag), 8'd2);
    cycle(acc);
    cmd_valid = 1'b0;
    cycle(acc);
    chk("bp_full_again", 8'(cmd_ready), 8'd0);
    chk("bp_head_data", rsp_data, 8'h10);
    drain();

    // Simultaneous push and pop with one entry held
    drive(4'd7, 4'd9, 4'd0, 2'd1);
    cycle(acc);
    cmd_valid = 1'b0;
    cycle(acc);
    drive(4'd2, 4'd3, 4'd2, 2'd2);
    cycle(acc);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    cycle(acc);
    rsp_ready = 1'b0;
    chk("pp_valid", 8'(rsp_valid), 8'd1);
    chk("pp_new_head", rsp_data, 8'h06);
    chk("pp_new_tag", 8'(rsp_tag), 8'd2);
    cycle(acc);
    chk("pp_ready_one_left", 8'(cmd_ready), 8'd1);

    // Reset during ISSUE with one entry in the FIFO
    drive(4'd5, 4'd5, 4'd0, 2'd3);
    cycle(acc);
    cmd_valid = 1'b0;
    rst = 1'b1;
    cycle(acc);
    rst = 1'b0;
    chk("rsti_valid", 8'(rsp_valid), 8'd0);
    chk("rsti_alu_a", 8'(alu_a), 8'd0);
    chk("rsti_alu_sel", 8'(alu_sel), 8'd0);
    chk("rsti_ready", 8'(cmd_ready), 8'd1);
    rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cycle(acc);
      chk("rsti_no_stale", 8'(rsp_valid), 8'd0);
    end

    // Randomized traffic against the model, with occasional resets
    for (int c = 0; c < 600; c++) begin
      cmd_valid = ($urandom_range(0, 3) != 0);
      cmd_a     = 4'($urandom_range(0, 15));
      cmd_b     = 4'($urandom_range(0, 15));
      cmd_sel   = 4'($urandom_range(0, 15));
      cmd_tag   = 2'($urandom_range(0, 3));
      rsp_ready = ($urandom_range(0, 2) != 0);
      rst       = ($urandom_range(0, 79) == 0);
      cycle(acc);
    end
    rst = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
